// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: phase encoding,
// lamp encodings and counter/watchdog defaults used by sequencer and enable generator.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        PED_WALK    = 3'd6
    } phase_t;

    // Lamp encodings are one-hot {red, yellow, green}.
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam int TRAFFIC_CNT_W    = 6;
    localparam int TRAFFIC_WDOG_MAX = 63;

    // Fixed phase order; the pedestrian phase is only inserted after ALL_RED_2.
    function automatic phase_t next_phase(input phase_t cur, input logic ped);
        phase_t nxt;
        nxt = MAIN_GREEN;
        case (cur)
            MAIN_GREEN:  nxt = MAIN_YELLOW;
            MAIN_YELLOW: nxt = ALL_RED_1;
            ALL_RED_1:   nxt = SIDE_GREEN;
            SIDE_GREEN:  nxt = SIDE_YELLOW;
            SIDE_YELLOW: nxt = ALL_RED_2;
            ALL_RED_2:   nxt = ped ? PED_WALK : MAIN_GREEN;
            PED_WALK:    nxt = MAIN_GREEN;
            default:     nxt = MAIN_GREEN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ped_request_latch.sv
// Pedestrian request latch: set/clear register, set beats clear, reset beats both.
// Latency: one clock from set/clear to output; no backpressure (level in, level out).
module ped_request_latch (
    input  logic clk,
    input  logic reset,
    input  logic set_i,
    input  logic clr_i,
    output logic req_o
);

    logic req_q;
    logic req_d;

    always_comb begin
        req_d = req_q;
        if (set_i) begin
            req_d = 1'b1;
        end else if (clr_i) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/light_sequencer.sv
// Phase sequencer: steps lights on enable pulses, owns the cycle counter, pedestrian latch and watchdog.
// Latency: new phase visible one clock after the enable edge; no backpressure, enable is a single-cycle pulse.
module light_sequencer
    import traffic_pkg::*;
#(
    parameter int CNT_W    = TRAFFIC_CNT_W,
    parameter int WDOG_MAX = TRAFFIC_WDOG_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ped_btn,
    output logic [CNT_W-1:0] counter,
    output logic             ped_req,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             walk,
    output logic             fault
);

    localparam logic [CNT_W-1:0] WDOG_VAL = CNT_W'(WDOG_MAX);

    phase_t           state_q;
    phase_t           state_d;
    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] counter_d;
    logic             fault_q;
    logic             fault_d;

    logic             wdog_fire;
    logic             cycle_end;
    logic             ped_clr;
    logic             ped_req_w;

    ped_request_latch u_ped_latch (
        .clk   (clk),
        .reset (reset),
        .set_i (ped_btn),
        .clr_i (ped_clr),
        .req_o (ped_req_w)
    );

    // A cycle ends whenever MAIN_GREEN is re-entered on an enable; the counter
    // must read 0 for exactly that one clock so the generator can reload.
    always_comb begin
        wdog_fire = (counter_q == WDOG_VAL) && !enable;
        ped_clr   = enable && (state_q == PED_WALK);
        cycle_end = enable && ((state_q == PED_WALK) ||
                               ((state_q == ALL_RED_2) && !ped_req_w));
    end

    always_comb begin
        state_d = state_q;
        if (wdog_fire) begin
            state_d = MAIN_GREEN;
        end else if (enable) begin
            state_d = next_phase(state_q, ped_req_w);
        end
    end

    always_comb begin
        counter_d = counter_q + CNT_W'(1);
        if (wdog_fire || cycle_end) begin
            counter_d = '0;
        end
    end

    always_comb begin
        fault_d = fault_q | wdog_fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MAIN_GREEN;
            counter_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            fault_q   <= fault_d;
        end
    end

    // Lamps are a pure decode of the registered phase.
    always_comb begin
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
        walk       = 1'b0;
        case (state_q)
            MAIN_GREEN:  main_light = LIGHT_GREEN;
            MAIN_YELLOW: main_light = LIGHT_YELLOW;
            SIDE_GREEN:  side_light = LIGHT_GREEN;
            SIDE_YELLOW: side_light = LIGHT_YELLOW;
            PED_WALK:    walk       = 1'b1;
            default: begin
                main_light = LIGHT_RED;
                side_light = LIGHT_RED;
            end
        endcase
    end

    assign counter = counter_q;
    assign ped_req = ped_req_w;
    assign fault   = fault_q;

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Phase sequencer for the intersection controller. It owns the 6-bit cycle `counter` and the latched pedestrian request `ped_req`, both of which feed the enable generator. It consumes that generator's single-cycle `enable` pulses to step the main-road, side-road and walk lights through the fixed phase order. It also runs a counter watchdog that forces a safe restart if an expected `enable` never arrives.

## Interface
- `CNT_W`, default 6: width of the cycle counter.
- `WDOG_MAX`, default 63: counter value at which the watchdog fires.

- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: phase-advance pulse from the enable generator, combinational from `counter`.
- `ped_btn`, input, 1: raw pedestrian button, level or pulse.
- `counter`, output, CNT_W: cycle counter. It is 0 on the first clock of every cycle.
- `ped_req`, output, 1: latched pedestrian request. It drives the generator's `PED` input.
- `main_light`, output, 3: one-hot {red, yellow, green}.
- `side_light`, output, 3: one-hot {red, yellow, green}.
- `walk`, output, 1: pedestrian walk lamp.
- `fault`, output, 1: sticky watchdog flag.

## Operation
- States, in order: `MAIN_GREEN` → `MAIN_YELLOW` → `ALL_RED_1` → `SIDE_GREEN` → `SIDE_YELLOW` → `ALL_RED_2` → (`PED_WALK`) → `MAIN_GREEN`.
- The state advances only on a rising edge where `enable`=1. Otherwise it holds.
- Exit from `ALL_RED_2`:
  - goes to `PED_WALK` if `ped_req`=1 at that edge;
  - goes to `MAIN_GREEN` otherwise.
- `PED_WALK` always exits to `MAIN_GREEN`.
- Light outputs are a pure decode of the state:
  - main is green/yellow only in `MAIN_GREEN`/`MAIN_YELLOW`, red elsewhere;
  - side is green/yellow only in `SIDE_GREEN`/`SIDE_YELLOW`, red elsewhere;
  - `walk`=1 only in `PED_WALK`, and both roads are red there.
- Counter:
  - cleared to 0 on any edge that enters `MAIN_GREEN`, whether from `ALL_RED_2`, from `PED_WALK`, or by the watchdog;
  - otherwise increments by 1;
  - never wraps, because the watchdog acts first.
- Pedestrian latch:
  - set on any edge with `ped_btn`=1;
  - cleared on the edge leaving `PED_WALK`;
  - if set and clear occur on the same edge, set wins and the request carries to the next cycle.
- Watchdog:
  - fires on the edge where `counter`=WDOG_MAX and `enable`=0;
  - forces the state to `MAIN_GREEN`, sets `counter` to 0 and sets `fault`=1;
  - `ped_req` is unaffected;
  - `fault` clears only on `reset`.
- Reset values: state `MAIN_GREEN`, `counter`=0, `ped_req`=0, `fault`=0, `main_light`=001, `side_light`=100, `walk`=0.

## Timing
- All outputs are registered or decoded from registered state. The block has no combinational path from any input to any output.
- An `enable` sampled at counter N makes the new state visible when the counter reads N+1, or when the counter reads 0 on cycle exit.
- With equal traffic (enables at 11, 13, 15, 25, 27, 29, plus 39 with PED), main green spans counter 0..11.
- The generator loads traffic levels at counter 0, so `counter`=0 must last exactly one clock per cycle.
- `ped_req` rising after the `ALL_RED_2` exit edge is served in the next cycle.
- `reset` mid-phase: on the next edge all reset values apply, regardless of `enable` or `ped_btn` in that cycle.

## Structure
- Shared package `traffic_pkg` holds:
  - the state enum `phase_t`;
  - the light encodings `LIGHT_RED`=3'b100, `LIGHT_YELLOW`=3'b010, `LIGHT_GREEN`=3'b001;
  - `CNT_W` and `WDOG_MAX` defaults, for use by the enable generator too.
- One sub-module, `ped_request_latch`: set/clear register with set priority and synchronous reset.
- Counter, FSM and watchdog stay in `light_sequencer`.

## Test plan
- Reset, then no `ped_btn`; bench drives `enable` at 11, 13, 15, 25, 27, 29.
  - Required: `main_light`=001 for counter 0..11 and 010 for 12..13.
  - Required: all-red for 14..15, side green for 16..25, side yellow for 26..27, all-red for 28..29.
  - Required: `counter`=0 on the next clock; cycle length 30 clocks.
- `ped_btn` pulse at counter 5 plus enable at 39.
  - Required: `ped_req`=1 from counter 6.
  - Required: `walk`=1 for counter 30..39, with both roads red.
  - Required: `ped_req`=0 and counter 0 after the exit edge; cycle length 40 clocks.
- `ped_btn`=1 on the same edge as the `PED_WALK` exit.
  - Required: `ped_req` stays 1 and the next cycle also walks.
- Enables withheld after counter 15.
  - Required: at the edge with counter 63, state becomes `MAIN_GREEN`, counter becomes 0 and `fault`=1.
  - Required: `fault` stays 1 across later normal cycles until `reset`.
- `reset` asserted in `SIDE_GREEN` with `ped_req`=1.
  - Required: next clock shows counter 0, `main_light`=001, `ped_req`=0 and `fault`=0.
